ex_mem_pipe: RTL and testbench

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

---
 rtl/ex_mem_pipe.sv | 155 +++++++++++++++
 tb/tb_ex_mem_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: two-entry skid buffer (main + skid) with a forwarding tap.
// Optional stall counter output enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_pipe #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [RD_W-1:0]   rd_addr_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              reg_write_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [RD_W-1:0]   rd_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              reg_write_o,
    output logic              fwd_en_o,
    output logic [RD_W-1:0]   fwd_rd_o,
    output logic [DATA_W-1:0] fwd_data_o
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic [RD_W-1:0]   rd;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   valid_q, valid_d;
    logic   ready_q, ready_d;
    logic   accept;

    always_comb begin
        in_entry.result     = alu_result_i;
        in_entry.store_data = store_data_i;
        in_entry.rd         = rd_addr_i;
        in_entry.mem_read   = mem_read_i;
        in_entry.mem_write  = mem_write_i;
        in_entry.reg_write  = reg_write_i;

        accept  = valid_i & ready_q;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (ready_i && accept) begin
                    main_d = in_entry;
                end else if (ready_i) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (ready_i) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush wins over every handshake; the payload is left as-is since it is dead once EMPTY.
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        valid_d = (state_d != EMPTY);
        ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o      = ready_q;
    assign valid_o      = valid_q;
    assign result_o     = main_q.result;
    assign store_data_o = main_q.store_data;
    assign rd_addr_o    = main_q.rd;
    assign mem_read_o   = valid_q & main_q.mem_read;
    assign mem_write_o  = valid_q & main_q.mem_write;
    assign reg_write_o  = valid_q & main_q.reg_write;

    // x0 is hardwired zero, so a write to it must never be forwarded.
    assign fwd_en_o   = valid_q & main_q.reg_write & (main_q.rd != '0);
    assign fwd_rd_o   = main_q.rd;
    assign fwd_data_o = main_q.result;

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_q && !ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: vector table, directed corner sequences, random traffic
// checked against a FIFO scoreboard of accepted entries.
module tb_ex_mem_pipe;

    localparam int DATA_W = 64;
    localparam int RD_W   = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid_i, ready_o, flush_i;
    logic [DATA_W-1:0] alu_result_i, store_data_i;
    logic [RD_W-1:0]   rd_addr_i;
    logic              mem_read_i, mem_write_i, reg_write_i;
    logic              valid_o, ready_i;
    logic [DATA_W-1:0] result_o, store_data_o;
    logic [RD_W-1:0]   rd_addr_o;
    logic              mem_read_o, mem_write_o, reg_write_o;
    logic              fwd_en_o;
    logic [RD_W-1:0]   fwd_rd_o;
    logic [DATA_W-1:0] fwd_data_o;
`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0]       stall_cnt_o;
`endif

    ex_mem_pipe #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .flush_i      (flush_i),
        .alu_result_i (alu_result_i),
        .store_data_i (store_data_i),
        .rd_addr_i    (rd_addr_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .reg_write_i  (reg_write_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result_o),
        .store_data_o (store_data_o),
        .rd_addr_o    (rd_addr_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .reg_write_o  (reg_write_o),
        .fwd_en_o     (fwd_en_o),
        .fwd_rd_o     (fwd_rd_o),
        .fwd_data_o   (fwd_data_o)
`ifdef EX_MEM_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        logic [63:0] sd;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
        logic        rw;
    } ent_t;

    typedef struct {
        logic        v, r, f, mw, rw;
        logic [4:0]  rd;
        logic [63:0] res;
        logic        ev, er, efwd, emw;
        logic [4:0]  erd;
        logic [63:0] eres;
    } vec_t;

    ent_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;
    int   pops0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: occupancy of the model FIFO must match valid_o/ready_o, head must match outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            chk("sb_valid", valid_o, sb.size() != 0);
            chk("sb_ready", ready_o, sb.size() < 2);
            if (valid_o && sb.size() != 0) begin
                chk("sb_result", result_o, sb[0].res);
                chk("sb_store", store_data_o, sb[0].sd);
                chk("sb_rd", rd_addr_o, sb[0].rd);
                chk("sb_mr", mem_read_o, sb[0].mr);
                chk("sb_mw", mem_write_o, sb[0].mw);
                chk("sb_rw", reg_write_o, sb[0].rw);
                chk("sb_fwd_en", fwd_en_o, sb[0].rw & (sb[0].rd != 5'd0));
                chk("sb_fwd_rd", fwd_rd_o, sb[0].rd);
                chk("sb_fwd_data", fwd_data_o, sb[0].res);
            end else if (!valid_o) begin
                chk("sb_gated", {mem_read_o, mem_write_o, reg_write_o, fwd_en_o}, 4'b0);
            end
            if (flush_i) begin
                sb.delete();
            end else begin
                if (valid_o && ready_i && sb.size() != 0) begin
                    void'(sb.pop_front());
                    n_pops++;
                end
                if (valid_i && ready_o) begin
                    sb.push_back('{res: alu_result_i, sd: store_data_i, rd: rd_addr_i,
                                   mr: mem_read_i, mw: mem_write_i, rw: reg_write_i});
                end
            end
        end
    end

    task automatic drive(input logic v, input logic r, input logic f, input logic mr,
                         input logic mw, input logic rw, input logic [4:0] rd, input logic [63:0] res);
        valid_i      = v;
        ready_i      = r;
        flush_i      = f;
        mem_read_i   = mr;
        mem_write_i  = mw;
        reg_write_i  = rw;
        rd_addr_i    = rd;
        alu_result_i = res;
        store_data_i = ~res;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];

    initial begin
        //            v  r  f mw rw rd     res        ev er fwd emw erd   eres
        vecs[0] = '{1, 1, 0, 0, 1, 5'd7, 64'h1234, 1, 1, 1, 0, 5'd7, 64'h1234};
        vecs[1] = '{0, 1, 0, 0, 0, 5'd0, 64'h0,    0, 1, 0, 0, 5'd0, 64'h0};
        vecs[2] = '{1, 1, 0, 0, 1, 5'd0, 64'h55,   1, 1, 0, 0, 5'd0, 64'h55};
        vecs[3] = '{0, 1, 0, 1, 0, 5'd0, 64'h0,    0, 1, 0, 0, 5'd0, 64'h0};
        vecs[4] = '{1, 0, 0, 1, 0, 5'd3, 64'hA,    1, 1, 0, 1, 5'd3, 64'hA};
        vecs[5] = '{1, 0, 0, 0, 1, 5'd4, 64'hB,    1, 0, 0, 1, 5'd3, 64'hA};
        vecs[6] = '{1, 0, 0, 0, 1, 5'd5, 64'hC,    1, 0, 0, 1, 5'd3, 64'hA};
        vecs[7] = '{1, 0, 1, 0, 1, 5'd6, 64'hD,    0, 1, 0, 0, 5'd0, 64'h0};
        vecs[8] = '{0, 1, 0, 0, 0, 5'd0, 64'h0,    0, 1, 0, 0, 5'd0, 64'h0};

        rst_n = 1'b0;
        valid_i = 0; ready_i = 0; flush_i = 0; mem_read_i = 0; mem_write_i = 0;
        reg_write_i = 0; rd_addr_i = '0; alu_result_i = '0; store_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_result", result_o, 64'h0);
        chk("rst_fwd_en", fwd_en_o, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].v, vecs[i].r, vecs[i].f, 1'b0, vecs[i].mw, vecs[i].rw, vecs[i].rd, vecs[i].res);
            $display("vec %0d: valid_o=%0b ready_o=%0b result_o=%0h fwd_en_o=%0b", i, valid_o, ready_o, result_o, fwd_en_o);
            chk($sformatf("vec%0d_valid", i), valid_o, vecs[i].ev);
            chk($sformatf("vec%0d_ready", i), ready_o, vecs[i].er);
            chk($sformatf("vec%0d_fwd_en", i), fwd_en_o, vecs[i].efwd);
            chk($sformatf("vec%0d_mem_write", i), mem_write_o, vecs[i].emw);
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_result", i), result_o, vecs[i].eres);
                chk($sformatf("vec%0d_fwd_rd", i), fwd_rd_o, vecs[i].erd);
            end
        end

        // Back-pressure ordering: A, B fill the buffer, C waits, then all drain in order.
        pops0 = n_pops;
        drive(1, 0, 0, 0, 0, 1, 5'd1, 64'hAAAA);
        drive(1, 0, 0, 0, 0, 1, 5'd2, 64'hBBBB);
        chk("order_full_ready", ready_o, 1'b0);
        drive(1, 0, 0, 0, 0, 1, 5'd3, 64'hCCCC);
        chk("order_held_ready", ready_o, 1'b0);
        chk("order_held_result", result_o, 64'hAAAA);
        drive(1, 1, 0, 0, 0, 1, 5'd3, 64'hCCCC);
        chk("order_b_result", result_o, 64'hBBBB);
        drive(1, 1, 0, 0, 0, 1, 5'd3, 64'hCCCC);
        chk("order_c_result", result_o, 64'hCCCC);
        drive(0, 1, 0, 0, 0, 0, 5'd0, 64'h0);
        drive(0, 1, 0, 0, 0, 0, 5'd0, 64'h0);
        $display("order: pops=%0d sb=%0d", n_pops - pops0, sb.size());
        chk("order_pops", n_pops - pops0, 3);
        chk("order_drained", sb.size(), 0);

        // Flush while FULL with C presented.
        pops0 = n_pops;
        drive(1, 0, 0, 0, 0, 1, 5'd1, 64'h1111);
        drive(1, 0, 0, 0, 0, 1, 5'd2, 64'h2222);
        drive(1, 0, 1, 0, 0, 1, 5'd3, 64'h3333);
        $display("flush: valid_o=%0b ready_o=%0b", valid_o, ready_o);
        chk("flush_valid", valid_o, 1'b0);
        chk("flush_ready", ready_o, 1'b1);
        drive(0, 1, 0, 0, 0, 0, 5'd0, 64'h0);
        drive(0, 1, 0, 0, 0, 0, 5'd0, 64'h0);
        chk("flush_no_pops", n_pops - pops0, 0);

        // Asynchronous reset mid-cycle while ONE.
        drive(1, 0, 0, 1, 1, 1, 5'd9, 64'h9999);
        #2;
        rst_n = 1'b0;
        valid_i = 1'b0;
        #1;
        $display("async rst: valid_o=%0b result_o=%0h ready_o=%0b", valid_o, result_o, ready_o);
        chk("arst_valid", valid_o, 1'b0);
        chk("arst_result", result_o, 64'h0);
        chk("arst_rd", rd_addr_o, 5'd0);
        chk("arst_ctrl", {mem_read_o, mem_write_o, reg_write_o, fwd_en_o}, 4'b0);
        chk("arst_ready", ready_o, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 0, 1, 5'd12, 64'h7777);
        chk("arst_after_valid", valid_o, 1'b1);
        chk("arst_after_result", result_o, 64'h7777);
        drive(0, 1, 0, 0, 0, 0, 5'd0, 64'h0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                  1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), {$urandom, $urandom});
        end
        repeat (4) drive(0, 1, 0, 0, 0, 0, 5'd0, 64'h0);
        $display("random: pops=%0d sb=%0d", n_pops, sb.size());
        chk("random_drained", sb.size(), 0);

`ifdef EX_MEM_STALL_CNT_EN
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 1, 5'd1, 64'h42);
        repeat (10) drive(0, 0, 0, 0, 0, 0, 5'd0, 64'h0);
        $display("stall: stall_cnt_o=%0d", stall_cnt_o);
        chk("stall_cnt_10", stall_cnt_o, 32'd10);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.stall_cnt_q;
        repeat (2) drive(0, 0, 0, 0, 0, 0, 5'd0, 64'h0);
        chk("stall_cnt_sat", stall_cnt_o, 32'hFFFF_FFFF);
        drive(0, 1, 0, 0, 0, 0, 5'd0, 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
